// File: rtl/fir_host_loader.sv
// fir_host_loader: byte-stream front end for FIR_main.
// Parses a framed header, loads the coefficient and sample RAMs, programs the
// length registers, starts the filter and streams the result RAM back out as
// big-endian bytes.
module fir_host_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_WSP   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wsp_wr,
    output logic [4:0]  wsp_addr,
    output logic [15:0] wsp_data,
    output logic        prb_wr,
    output logic [12:0] prb_addr,
    output logic [15:0] prb_data,
    output logic [12:0] wyn_addr,
    input  logic [15:0] wyn_data,
    output logic [5:0]  ile_wsp,
    output logic [13:0] ile_probek,
    output logic [14:0] ile_razy,
    output logic        fir_start,
    input  logic        fir_done,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_H_W  = 4'd1;
    localparam logic [3:0] S_H_P1 = 4'd2;
    localparam logic [3:0] S_H_P0 = 4'd3;
    localparam logic [3:0] S_C_HI = 4'd4;
    localparam logic [3:0] S_C_LO = 4'd5;
    localparam logic [3:0] S_P_HI = 4'd6;
    localparam logic [3:0] S_P_LO = 4'd7;
    localparam logic [3:0] S_RUN  = 4'd8;
    localparam logic [3:0] S_RD   = 4'd9;
    localparam logic [3:0] S_RW   = 4'd10;
    localparam logic [3:0] S_T_HI = 4'd11;
    localparam logic [3:0] S_T_LO = 4'd12;

    localparam logic [6:0] LP_MAX_WSP = 7'(MAX_WSP);

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic [5:0]  r_nwsp;
    logic [5:0]  r_nprb_hi;
    logic [13:0] r_k;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_started;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_wsp_wr;
    logic [4:0]  r_wsp_addr;
    logic [15:0] r_wsp_data;
    logic        r_prb_wr;
    logic [12:0] r_prb_addr;
    logic [15:0] r_prb_data;
    logic [12:0] r_wyn_addr;
    logic [5:0]  r_ile_wsp;
    logic [13:0] r_ile_probek;
    logic [14:0] r_ile_razy;
    logic        r_fir_start;
    logic        r_busy;
    logic        r_err;

    logic        w_rx_hs;
    logic        w_tx_hs;
    logic [13:0] w_nprb;
    logic [14:0] w_razy;
    logic        w_hdr_bad;
    logic        w_last_wsp;
    logic        w_last_prb;
    logic        w_last_res;

    // Loader accepts bytes in every parsing/loading state, never while running or reading out
    assign rx_ready = (r_state <= S_P_LO);
    assign w_rx_hs  = rx_valid & rx_ready;
    assign w_tx_hs  = r_tx_valid & tx_ready;

    // N_PRB lo byte is still on rx_data during the H_P0 handshake
    assign w_nprb     = {r_nprb_hi, rx_data};
    assign w_razy     = {9'd0, r_nwsp} + {1'b0, w_nprb} - 15'd1;
    assign w_hdr_bad  = (r_nwsp == 6'd0) || ({1'b0, r_nwsp} > LP_MAX_WSP) ||
                        (w_nprb == 14'd0) || (w_razy > 15'd8192);
    assign w_last_wsp = (r_k == {8'd0, r_ile_wsp} - 14'd1);
    assign w_last_prb = (r_k == r_ile_probek - 14'd1);
    assign w_last_res = ({1'b0, r_k} == r_ile_razy - 15'd1);

    // Next-state decode of the frame parser / run / readout sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_rx_hs && rx_data == SYNC_BYTE) w_state_next = S_H_W;
            S_H_W:  if (w_rx_hs) w_state_next = S_H_P1;
            S_H_P1: if (w_rx_hs) w_state_next = S_H_P0;
            S_H_P0: if (w_rx_hs) w_state_next = w_hdr_bad ? S_IDLE : S_C_HI;
            S_C_HI: if (w_rx_hs) w_state_next = S_C_LO;
            S_C_LO: if (w_rx_hs) w_state_next = w_last_wsp ? S_P_HI : S_C_HI;
            S_P_HI: if (w_rx_hs) w_state_next = S_P_LO;
            S_P_LO: if (w_rx_hs) w_state_next = w_last_prb ? S_RUN : S_P_HI;
            S_RUN:  if (r_started && fir_done) w_state_next = S_RD;
            S_RD:   w_state_next = S_RW;
            S_RW:   w_state_next = S_T_HI;
            S_T_HI: if (w_tx_hs) w_state_next = S_T_LO;
            S_T_LO: if (w_tx_hs) w_state_next = w_last_res ? S_IDLE : S_RD;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_nwsp       <= 6'd0;
            r_nprb_hi    <= 6'd0;
            r_k          <= 14'd0;
            r_hi         <= 8'd0;
            r_lo         <= 8'd0;
            r_started    <= 1'b0;
            r_tx_data    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_wsp_wr     <= 1'b0;
            r_wsp_addr   <= 5'd0;
            r_wsp_data   <= 16'd0;
            r_prb_wr     <= 1'b0;
            r_prb_addr   <= 13'd0;
            r_prb_data   <= 16'd0;
            r_wyn_addr   <= 13'd0;
            r_ile_wsp    <= 6'd0;
            r_ile_probek <= 14'd0;
            r_ile_razy   <= 15'd0;
            r_fir_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_wsp_wr    <= 1'b0;
            r_prb_wr    <= 1'b0;
            r_fir_start <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_H_W:  if (w_rx_hs) r_nwsp <= rx_data[5:0];
                S_H_P1: if (w_rx_hs) r_nprb_hi <= rx_data[5:0];
                S_H_P0: begin
                    if (w_rx_hs) begin
                        if (w_hdr_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ile_wsp    <= r_nwsp;
                            r_ile_probek <= w_nprb;
                            r_ile_razy   <= w_razy;
                            r_k          <= 14'd0;
                        end
                    end
                end
                S_C_HI, S_P_HI: if (w_rx_hs) r_hi <= rx_data;
                S_C_LO: begin
                    if (w_rx_hs) begin
                        r_wsp_wr   <= 1'b1;
                        r_wsp_addr <= r_k[4:0];
                        r_wsp_data <= {r_hi, rx_data};
                        r_k        <= w_last_wsp ? 14'd0 : r_k + 14'd1;
                    end
                end
                S_P_LO: begin
                    if (w_rx_hs) begin
                        r_prb_wr   <= 1'b1;
                        r_prb_addr <= r_k[12:0];
                        r_prb_data <= {r_hi, rx_data};
                        r_k        <= w_last_prb ? 14'd0 : r_k + 14'd1;
                        r_started  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Start goes out one cycle after the final sample write
                    if (!r_started) begin
                        r_fir_start <= 1'b1;
                        r_started   <= 1'b1;
                    end else if (fir_done) begin
                        r_started  <= 1'b0;
                        r_k        <= 14'd0;
                        r_wyn_addr <= 13'd0;
                    end
                end
                S_RW: begin
                    // Address was on the bus during RD, so read data is valid now
                    r_lo       <= wyn_data[7:0];
                    r_tx_data  <= wyn_data[15:8];
                    r_tx_valid <= 1'b1;
                end
                S_T_HI: if (w_tx_hs) r_tx_data <= r_lo;
                S_T_LO: begin
                    if (w_tx_hs) begin
                        r_tx_valid <= 1'b0;
                        if (!w_last_res) begin
                            r_k        <= r_k + 14'd1;
                            r_wyn_addr <= r_k[12:0] + 13'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign wsp_wr     = r_wsp_wr;
    assign wsp_addr   = r_wsp_addr;
    assign wsp_data   = r_wsp_data;
    assign prb_wr     = r_prb_wr;
    assign prb_addr   = r_prb_addr;
    assign prb_data   = r_prb_data;
    assign wyn_addr   = r_wyn_addr;
    assign ile_wsp    = r_ile_wsp;
    assign ile_probek = r_ile_probek;
    assign ile_razy   = r_ile_razy;
    assign fir_start  = r_fir_start;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_fir_host_loader.sv
// Testbench for fir_host_loader: frames are built from a high-level model,
// expected RAM writes and tx bytes are queued, monitors pop and compare.
`timescale 1ns/1ps
module tb_fir_host_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wsp_wr;
    logic [4:0]  wsp_addr;
    logic [15:0] wsp_data;
    logic        prb_wr;
    logic [12:0] prb_addr;
    logic [15:0] prb_data;
    logic [12:0] wyn_addr;
    logic [15:0] wyn_data;
    logic [5:0]  ile_wsp;
    logic [13:0] ile_probek;
    logic [14:0] ile_razy;
    logic        fir_start;
    logic        fir_done = 1'b0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    fir_host_loader #(.SYNC_BYTE(8'hA5), .MAX_WSP(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wsp_wr(wsp_wr), .wsp_addr(wsp_addr), .wsp_data(wsp_data),
        .prb_wr(prb_wr), .prb_addr(prb_addr), .prb_data(prb_data),
        .wyn_addr(wyn_addr), .wyn_data(wyn_data),
        .ile_wsp(ile_wsp), .ile_probek(ile_probek), .ile_razy(ile_razy),
        .fir_start(fir_start), .fir_done(fir_done),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] res_mem [0:8191];
    logic [28:0] exp_wsp[$];
    logic [28:0] exp_prb[$];
    logic [7:0]  exp_tx[$];
    int start_cnt = 0, err_cnt = 0, exp_start = 0, exp_err = 0;
    int m_ile_wsp = 0, m_ile_prb = 0, m_ile_razy = 0;
    bit hold_low = 1'b0;
    bit rand_ready = 1'b0;
    int done_delay = 50;
    logic [15:0] fr_coef[$];
    logic [15:0] fr_samp[$];
    logic [15:0] fr_res[$];
    logic [7:0]  fr_pre[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result RAM model: synchronous read, one cycle latency
    always @(posedge clk) wyn_data <= res_mem[wyn_addr];

    // FIR_main stand-in: done pulse a programmable number of cycles after start
    initial begin
        forever begin
            @(negedge clk);
            if (fir_start) begin
                repeat (done_delay) @(posedge clk);
                #1 fir_done = 1'b1;
                @(posedge clk);
                #1 fir_done = 1'b0;
            end
        end
    end

    // Sink: always ready, random ready, or held off
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) tx_ready = 1'b0;
            else if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
            else tx_ready = 1'b1;
        end
    end

    // Monitor: pops expected writes / bytes whenever the DUT presents them
    initial begin
        logic [28:0] e;
        logic        stall_prev;
        logic [7:0]  stall_data;
        stall_prev = 1'b0;
        stall_data = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (wsp_wr) begin
                check("wsp_write_expected", 32'(exp_wsp.size() != 0), 32'd1);
                if (exp_wsp.size() != 0) begin
                    e = exp_wsp.pop_front();
                    check("wsp_addr", 32'(wsp_addr), 32'(e[28:16]));
                    check("wsp_data", 32'(wsp_data), 32'(e[15:0]));
                end
            end
            if (prb_wr) begin
                check("prb_write_expected", 32'(exp_prb.size() != 0), 32'd1);
                if (exp_prb.size() != 0) begin
                    e = exp_prb.pop_front();
                    check("prb_addr", 32'(prb_addr), 32'(e[28:16]));
                    check("prb_data", 32'(prb_data), 32'(e[15:0]));
                end
            end
            if (fir_start) begin
                start_cnt++;
                check("start_no_ram_write", 32'(wsp_wr | prb_wr), 32'd0);
            end
            if (err) err_cnt++;
            if (stall_prev) begin
                check("tx_valid_held", 32'(tx_valid), 32'd1);
                check("tx_data_stable", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                check("tx_byte_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_ready && n < 5000);
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic fill_random(input int nw, input int np);
        fr_coef.delete();
        fr_samp.delete();
        fr_res.delete();
        for (int i = 0; i < nw; i++) fr_coef.push_back(16'($urandom));
        for (int i = 0; i < np; i++) fr_samp.push_back(16'($urandom));
        for (int i = 0; i < nw + np - 1; i++) fr_res.push_back(16'($urandom));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_starts"}, 32'(start_cnt), 32'(exp_start));
        check({tag, "_errs"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_wsp_pending"}, 32'(exp_wsp.size()), 32'd0);
        check({tag, "_prb_pending"}, 32'(exp_prb.size()), 32'd0);
        check({tag, "_ile_wsp"}, 32'(ile_wsp), 32'(m_ile_wsp));
        check({tag, "_ile_probek"}, 32'(ile_probek), 32'(m_ile_prb));
        check({tag, "_ile_razy"}, 32'(ile_razy), 32'(m_ile_razy));
    endtask

    // Build one frame from the header rules, queue expectations, send and wait it out
    task automatic run_frame(input string tag, input logic [7:0] nw_b, input logic [7:0] np_hi,
                             input logic [7:0] np_lo, input bit gaps);
        int nw, np, razy, n;
        bit ok;
        logic [7:0] bytes[$];
        nw   = int'(nw_b) & 63;
        np   = ((int'(np_hi) << 8) | int'(np_lo)) & 16383;
        razy = nw + np - 1;
        ok   = (nw != 0) && (nw <= 32) && (np != 0) && (razy <= 8192);
        foreach (fr_pre[i]) bytes.push_back(fr_pre[i]);
        bytes.push_back(8'hA5);
        bytes.push_back(nw_b);
        bytes.push_back(np_hi);
        bytes.push_back(np_lo);
        if (ok) begin
            for (int k = 0; k < nw; k++) begin
                bytes.push_back(fr_coef[k][15:8]);
                bytes.push_back(fr_coef[k][7:0]);
                exp_wsp.push_back({13'(k), fr_coef[k]});
            end
            for (int k = 0; k < np; k++) begin
                bytes.push_back(fr_samp[k][15:8]);
                bytes.push_back(fr_samp[k][7:0]);
                exp_prb.push_back({13'(k), fr_samp[k]});
            end
            for (int k = 0; k < razy; k++) begin
                res_mem[k] = fr_res[k];
                exp_tx.push_back(fr_res[k][15:8]);
                exp_tx.push_back(fr_res[k][7:0]);
            end
            exp_start++;
            m_ile_wsp  = nw;
            m_ile_prb  = np;
            m_ile_razy = razy;
        end else begin
            exp_err++;
        end
        for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i], gaps);
        if (!ok) begin
            check({tag, "_err_pulse"}, 32'(err), 32'd1);
            @(posedge clk);
            #1;
            check({tag, "_err_single"}, 32'(err), 32'd0);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while ((busy || exp_tx.size() != 0) && n < 20000);
            check({tag, "_idle_after_readout"}, 32'(busy), 32'd0);
            check({tag, "_tx_pending"}, 32'(exp_tx.size()), 32'd0);
            @(posedge clk);
            #1;
        end
        check_state(tag);
        fr_pre.delete();
        fr_coef.delete();
        fr_samp.delete();
        fr_res.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, 32'({tx_valid, wsp_wr, prb_wr, fir_start, busy, err, rx_ready}),
              32'h1);
        check({tag, "_wsp_port"}, 32'({wsp_addr, wsp_data}), 32'd0);
        check({tag, "_prb_port"}, 32'({prb_addr, prb_data}), 32'd0);
        check({tag, "_rd_tx"}, 32'({wyn_addr, tx_data}), 32'd0);
        check({tag, "_ile_wp"}, 32'({ile_wsp, ile_probek}), 32'd0);
        check({tag, "_ile_razy"}, 32'(ile_razy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, nw, np;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Averaging frame
        fr_coef = '{16'h4000, 16'h4000};
        fr_samp = '{16'hFC18, 16'hF830, 16'hF448, 16'hF060};
        fr_res  = '{16'hFE0C, 16'hFA24, 16'hF63C, 16'hF254, 16'hF830};
        run_frame("avg", 8'h02, 8'h00, 8'h04, 1'b0);

        // Rejected headers keep ile_* and produce no writes
        run_frame("zero_wsp", 8'h00, 8'h00, 8'h04, 1'b0);
        run_frame("wsp_33", 8'h21, 8'h00, 8'h04, 1'b0);
        run_frame("zero_prb", 8'h03, 8'hC0, 8'h00, 1'b0);
        run_frame("razy_8193", 8'h02, 8'h20, 8'h00, 1'b0);
        fill_random(3, 5);
        run_frame("after_reject", 8'h03, 8'h00, 8'h05, 1'b0);

        // Garbage before sync, with the sink held off for 20 cycles on the first byte
        fr_pre  = '{8'h13, 8'h37};
        fr_coef = '{16'h8000};
        fr_samp = '{16'h03E8};
        fr_res  = '{16'($urandom)};
        hold_low = 1'b1;
        fork
            run_frame("resync_stall", 8'h01, 8'h00, 8'h01, 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!tx_valid && n < 5000);
                check("stall_tx_valid_seen", 32'(tx_valid), 32'd1);
                repeat (20) @(negedge clk);
                hold_low = 1'b0;
            end
        join

        // Frame 1 again with rx gaps and random sink readiness
        rand_ready = 1'b1;
        fr_coef = '{16'h4000, 16'h4000};
        fr_samp = '{16'hFC18, 16'hF830, 16'hF448, 16'hF060};
        fr_res  = '{16'hFE0C, 16'hFA24, 16'hF63C, 16'hF254, 16'hF830};
        run_frame("avg_gaps", 8'h02, 8'h00, 8'h04, 1'b1);
        rand_ready = 1'b0;

        // Reset after the second coefficient byte
        exp_wsp.push_back({13'd0, 16'h4000});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_ile_wsp  = 0;
        m_ile_prb  = 0;
        m_ile_razy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");
        fill_random(2, 4);
        run_frame("fresh_after_reset", 8'h02, 8'h00, 8'h04, 1'b0);

        // Random legal frames, unused header bits set at random
        for (int f = 0; f < 4; f++) begin
            nw = (f == 0) ? 32 : int'($urandom_range(1, 32));
            np = int'($urandom_range(1, 12));
            fill_random(nw, np);
            rand_ready = 1'b1;
            done_delay = int'($urandom_range(1, 30));
            run_frame("random", 8'(nw | int'($urandom_range(0, 3) << 6)),
                      8'(int'($urandom_range(0, 3) << 6)), 8'(np), f[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_host_loader.md
# fir_host_loader

Host-side front end for `FIR_main`.
- Receives a framed byte stream (handshake in), writes the coefficient RAM and sample RAM, and programs the length registers.
- Starts the filter, waits for completion, then reads the result RAM and streams every result back as bytes (handshake out).
- Fills the role the bench fills today with backdoor RAM writes; it is the write and read end of the FIR RAM interface.

## Interface
Parameters:
- `SYNC_BYTE`, default `8'hA5`: frame start marker.
- `MAX_WSP`, default 32: maximum coefficient count. Must not exceed 2^5.

Ports:
- `clk` in, 1: single clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `rx_data` in, 8: incoming frame byte.
- `rx_valid` in, 1: `rx_data` is valid.
- `rx_ready` out, 1: loader accepts a byte. Handshake = `rx_valid & rx_ready`.
- `tx_data` out, 8: result byte.
- `tx_valid` out, 1: `tx_data` is valid.
- `tx_ready` in, 1: sink accepts. Handshake = `tx_valid & tx_ready`.
- `wsp_wr`, `wsp_addr[4:0]`, `wsp_data[15:0]` out: coefficient RAM write port.
- `prb_wr`, `prb_addr[12:0]`, `prb_data[15:0]` out: sample RAM write port.
- `wyn_addr` out, 13: result RAM read address.
- `wyn_data` in, 16: result RAM data. Synchronous read, 1-cycle latency.
- `ile_wsp` out, 6: coefficient count.
- `ile_probek` out, 14: sample count.
- `ile_razy` out, 15: number of outputs, `ile_wsp + ile_probek - 1`.
- `fir_start` out, 1: one-cycle start pulse to `FIR_main`.
- `fir_done` in, 1: FIR completion.
- `busy` out, 1: high in every state except IDLE.
- `err` out, 1: one-cycle pulse when a header is rejected.

## Operation
Frame format, big-endian: `SYNC_BYTE`, `N_WSP` (bits [5:0] used), `N_PRB` hi, `N_PRB` lo (bits [13:0] used), then `N_WSP` coefficients as hi,lo, then `N_PRB` samples as hi,lo.

State machine:
- IDLE: bytes other than `SYNC_BYTE` are consumed and dropped. This is the resync mechanism. `SYNC_BYTE` -> H_W.
- H_W: store `N_WSP` -> H_P1.
- H_P1 -> H_P0.
- H_P0: validate the header.
  - Reject if `N_WSP==0`, `N_WSP>MAX_WSP`, `N_PRB==0`, or `N_WSP+N_PRB-1 > 8192`. Rejection pulses `err` and returns to IDLE; `ile_*` keep their previous values.
  - Otherwise update `ile_wsp`, `ile_probek`, `ile_razy` and go to C_HI.
- C_HI / C_LO: assemble each 16-bit word.
  - Lo handshake -> write the coefficient at index k, k = 0..N_WSP-1.
  - After the last coefficient -> P_HI.
- P_HI / P_LO: same for samples, index 0..N_PRB-1. After the last sample -> RUN.
- RUN: pulse `fir_start` in the first RUN cycle, then wait for `fir_done==1` -> RD with k=0. `fir_done` is ignored in every other state.
- RD: drive `wyn_addr=k` -> RW.
- RW: capture `wyn_data` -> T_HI.
- T_HI: `tx_data=word[15:8]`; on handshake -> T_LO.
- T_LO: `tx_data=word[7:0]`; on handshake:
  - if `k==ile_razy-1` -> IDLE;
  - else k+1 -> RD.

Arithmetic and widths:
- `ile_razy` is computed in 15 bits; it cannot overflow for legal headers.
- Data is passed through unaltered; no sign handling.

## Timing
Reset values: `rx_ready` 1 (IDLE). `tx_valid`, `wsp_wr`, `prb_wr`, `fir_start`, `busy`, `err` are 0. All addresses, data, `tx_data` and `ile_*` are 0.

Registered outputs:
- All outputs except `rx_ready` are registered.
- `rx_ready = 1` in IDLE, H_*, C_*, P_*; 0 in RUN, RD, RW, T_*.

RAM writes:
- `wsp_wr`/`prb_wr` go high for exactly one cycle, the cycle after the lo-byte handshake.
- Address and data are valid in that same cycle.
- One write per two accepted bytes; at most one write per cycle.

Start and readout:
- The first RUN cycle is the cycle after the final sample write, so `fir_start` never overlaps a RAM write.
- Readout takes 2 cycles (RD, RW) from address to captured word. The captured word is held through T_HI/T_LO.

Handshakes:
- `tx_valid` stays high and `tx_data` stays stable until the handshake; backpressure may stall indefinitely.
- `rx_valid` gaps stall the FSM without losing state.

`err` fires in the cycle after the `N_PRB`-lo handshake.

Reset: asserting `rst_n` low mid-frame or mid-readout returns to IDLE immediately. `fir_start` drops, and no further RAM writes or tx bytes occur.

## Test plan
1. Averaging frame `A5 02 00 04 40 00 40 00 FC 18 F8 30 F4 48 F0 60`.
   - Expect `wsp[0..1]=4000h`, `prb[0..3]=FC18h,F830h,F448h,F060h`, `ile_wsp=2`, `ile_probek=4`, `ile_razy=5`.
   - Expect exactly one `fir_start`.
   - With a model result RAM `{FE0Ch,FA24h,F63Ch,F254h,F830h}` and `fir_done` returned after 50 cycles, expect tx `FE 0C FA 24 F6 3C F2 54 F8 30`, then IDLE.
2. Headers `A5 00 00 04` and `A5 21 00 04`.
   - Expect an `err` pulse each time, no RAM writes, and `ile_*` unchanged.
   - A following valid frame processes normally.
3. Bytes `13 37 A5 01 00 01 80 00 03 E8` (garbage before sync) -> `wsp[0]=8000h`, `prb[0]=03E8h`, `ile_razy=1`, one result word transmitted.
4. `tx_ready` held low for 20 cycles during T_HI -> `tx_valid` stays high and `tx_data` stays stable; no byte is lost or duplicated.
5. Random `rx_valid` gaps across all of frame 1 -> RAM contents identical to scenario 1.
6. `rst_n` low after the second coefficient byte -> all outputs at their reset values; no further writes; a fresh frame then succeeds.
